cla_alu_pipe: RTL and testbench
===============================

Name: cla_alu_pipe

Overview:
- Parametrised, two-stage pipelined carry-lookahead add/subtract unit with status flags and a carry flag register.
- The carry flag register supports multi-word add-with-carry and subtract-with-borrow chains.
- Sits between the operand issue logic and the result/flag writeback.
- Uses a valid/ready handshake on both the input and output sides.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of BLOCK.
- BLOCK, 4, lookahead group size; carries are computed in full lookahead within each group and rippled between groups.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept an operand beat
- op  input  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBC
- x  input  WIDTH  operand X
- y  input  WIDTH  operand Y
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts the result
- z  output  WIDTH  result
- sign  output  1  z[WIDTH-1]
- zero  output  1  z is all zeros
- carry  output  1  carry-out of the MSB group
- parity  output  1  even parity: 1 when z has an even number of ones
- overflow  output  1  signed overflow

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids clear; out_valid=0; z and all flags=0; carry flag register cf=0. Any in-flight operations are discarded.
- Stage 1 (S1) register loads op, x and the effective operand ye:
  - ye = y for ADD/ADC; ye = ~y for SUB/SBC.
  - Loads on input accept (in_valid & in_ready).
- Stage 2 (S2) computes and registers the result:
  - Evaluates z = x + ye + cin with carry-lookahead.
  - Per bit: p = x^ye, g = x&ye.
  - Per group: carries from the CLA equations. The group carry-out feeds the next group's carry-in.
- Carry-in selection: ADD cin=0; SUB cin=1; ADC and SBC cin=cf.
- carry = MSB carry-out. For SUB/SBC this is the no-borrow convention: 1 means no borrow.
- overflow = (x[MSB]==ye[MSB]) & (z[MSB]!=x[MSB]).
- cf loads the computed carry every time S2 loads. Ops therefore chain in issue order, and back-to-back ADC/SBC with no bubble sees the carry of the immediately preceding op.
- Latency: an accepted beat appears on out_valid exactly 2 cycles later when out_ready stays high. Sustained throughput is one op per cycle.
- Handshake:
  - S2 advances when !s2_valid | out_ready.
  - S1 advances when !s1_valid | S2 advances.
  - in_ready equals the S1-advance condition. It is combinational from out_ready; there is no combinational path from in_valid.
- Output hold: z, flags and out_valid stay stable while out_valid & !out_ready. A beat is consumed only on out_valid & out_ready.
- Simultaneous accept and consume: both happen in the same cycle; no bubble is inserted and no beat is dropped.
- Empty pipe: out_valid=0 and z/flags hold their last values.
- cf is not updated by bubbles or by stalled cycles.
- WIDTH % BLOCK != 0 is a configuration error; raise it as an elaboration-time check.

Test Plan:
- ADD x=0x7FFF, y=0x0001 -> z=0x8000, sign=1, overflow=1, carry=0, zero=0, parity=0; out_valid exactly 2 cycles after accept.
- SUB x=0x0005, y=0x0005 -> z=0x0000, zero=1, carry=1, parity=1, overflow=0. SUB x=0x8000, y=0x0001 -> z=0x7FFF, overflow=1, carry=1, sign=0, parity=0.
- Back-to-back ADD 0xFFFF+0x0001 then ADC 0x0000+0x0000 -> first z=0x0000 carry=1; second z=0x0001 carry=0. Then SBC 0x0000-0x0000 with cf=0 -> z=0xFFFF, carry=0, sign=1.
- Backpressure: issue 4 ops (x=1..4, y=0, ADD) every cycle with out_ready=0 -> in_ready drops after 2 accepts and outputs hold stable. Release out_ready -> results 1,2,3,4 appear in order with none lost or duplicated.
- Reset mid-operation: assert rst_n low while both stages are valid and cf=1 -> out_valid=0 and cf=0 immediately. After release, ADC 0x0001+0x0001 -> z=0x0002.
- Random sweep with WIDTH=32, BLOCK=8 against a behavioural reference: z, carry and overflow match for 10k ops with random out_ready stalls.

Source files
------------

// File: rtl/cla_alu_pipe.sv
// cla_alu_pipe: two-stage pipelined carry-lookahead add/sub unit with status flags and carry chaining.
// Latency: an accepted beat is presented on out_valid two cycles later; sustained throughput one op/cycle.
// Backpressure: skid-free valid/ready; in_ready = !s1_valid | !out_valid | out_ready (no path from in_valid).
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready      operand beat handshake; op (00 ADD, 01 SUB, 10 ADC, 11 SBC), x, y
//   out_valid/out_ready    result beat handshake; z plus sign, zero, carry, parity, overflow flags
module cla_alu_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             sign,
  output logic             zero,
  output logic             carry,
  output logic             parity,
  output logic             overflow
);

  localparam int NGRP = WIDTH / BLOCK;

  generate
    if (WIDTH % BLOCK != 0) begin : g_cfg_error
      $error("cla_alu_pipe: WIDTH (%0d) must be a multiple of BLOCK (%0d)", WIDTH, BLOCK);
    end
  endgenerate

  // Stage 1 state
  logic             s1_valid;
  logic [1:0]       s1_op;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_ye;

  // Carry flag used by ADC/SBC
  logic             cf;

  // Handshake
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: op[0] marks a subtract, so the operand is inverted here and the
  // +1 comes in as the carry-in in stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= 2'b00;
      s1_x     <= '0;
      s1_ye    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= op;
        s1_x  <= x;
        s1_ye <= op[0] ? ~y : y;
      end
    end
  end

  // Carry-lookahead evaluation of x + ye + cin
  logic             cin_sel;
  logic [WIDTH-1:0] pv;
  logic [WIDTH-1:0] gv;
  logic [WIDTH:0]   cv;
  logic [WIDTH-1:0] sum;
  logic             term;
  logic             gterm;
  logic             ovf_next;

  always_comb begin
    // ADD: 0, SUB: 1, ADC/SBC: carry flag
    cin_sel = s1_op[1] ? cf : s1_op[0];
    pv      = s1_x ^ s1_ye;
    gv      = s1_x & s1_ye;
    cv      = '0;
    term    = 1'b0;
    gterm   = 1'b0;
    cv[0]   = cin_sel;
    for (int grp = 0; grp < NGRP; grp++) begin
      // Every carry inside a group is a flat sum-of-products of that group's
      // p/g and its carry-in; only the group carry-out ripples onwards.
      for (int j = 1; j <= BLOCK; j++) begin
        term = cv[grp*BLOCK];
        for (int k = 0; k < j; k++) begin
          term = term & pv[grp*BLOCK+k];
        end
        for (int i = 0; i < j; i++) begin
          gterm = gv[grp*BLOCK+i];
          for (int k = i + 1; k < j; k++) begin
            gterm = gterm & pv[grp*BLOCK+k];
          end
          term = term | gterm;
        end
        cv[grp*BLOCK+j] = term;
      end
    end
    sum      = pv ^ cv[WIDTH-1:0];
    ovf_next = (s1_x[WIDTH-1] == s1_ye[WIDTH-1]) & (sum[WIDTH-1] != s1_x[WIDTH-1]);
  end

  // Stage 2: result and flag registers; everything holds while stalled or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      z         <= '0;
      sign      <= 1'b0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      parity    <= 1'b0;
      overflow  <= 1'b0;
      cf        <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        z        <= sum;
        sign     <= sum[WIDTH-1];
        zero     <= (sum == '0);
        carry    <= cv[WIDTH];
        parity   <= ~(^sum);
        overflow <= ovf_next;
        // Updated in issue order so a back-to-back ADC/SBC sees this carry.
        cf       <= cv[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_cla_alu_pipe.sv
// tb_cla_alu_pipe: directed checks on a 16-bit/4-bit-group instance plus a random sweep on 32/8.
// Latency: n/a (bench).
// Backpressure: drives out_ready both held low and randomly toggled.
module tb_cla_alu_pipe;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;
  localparam int NSWEEP = 10000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [1:0]  op16;
  logic [15:0] x16, y16, z16;
  logic        sign16, zero16, carry16, parity16, overflow16;
  logic [4:0]  flags16;
  assign flags16 = {sign16, zero16, carry16, parity16, overflow16};

  cla_alu_pipe #(.WIDTH(16), .BLOCK(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .op(op16), .x(x16), .y(y16),
    .out_valid(out_valid16), .out_ready(out_ready16), .z(z16),
    .sign(sign16), .zero(zero16), .carry(carry16), .parity(parity16), .overflow(overflow16)
  );

  // 32-bit instance
  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [1:0]  op32;
  logic [31:0] x32, y32, z32;
  logic        sign32, zero32, carry32, parity32, overflow32;

  cla_alu_pipe #(.WIDTH(32), .BLOCK(8)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid32), .in_ready(in_ready32), .op(op32), .x(x32), .y(y32),
    .out_valid(out_valid32), .out_ready(out_ready32), .z(z32),
    .sign(sign32), .zero(zero32), .carry(carry32), .parity(parity32), .overflow(overflow32)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    in_valid16 = 1'b1;
    op16       = o;
    x16        = a;
    y16        = b;
  endtask

  // Issue one op into an empty pipe with out_ready high; returns with the result on the outputs.
  task automatic one_op(input string tag, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    out_ready16 = 1'b1;
    drive16(o, a, b);
    #1;
    chk({tag, "_in_ready"}, in_ready16, 1);
    step();
    in_valid16 = 1'b0;
    #1;
    chk({tag, "_lat1_valid"}, out_valid16, 0);
    step();
    chk({tag, "_lat2_valid"}, out_valid16, 1);
  endtask

  // Sweep scoreboard
  logic        sweep_on = 1'b0;
  int          sent = 0;
  int          rcv = 0;
  logic        cf_m = 1'b0;
  logic [33:0] exp_q[$];
  logic [31:0] m_ye;
  logic        m_cin;
  logic [32:0] m_sum;
  logic        m_ovf;
  logic [33:0] m_exp;

  always @(negedge clk) begin
    if (rst_n && sweep_on) begin
      if (out_valid32 && out_ready32) begin
        if (exp_q.size() == 0) begin
          chk("sweep_spurious_beat", 1, 0);
        end else begin
          m_exp = exp_q.pop_front();
          chk("sweep_z_carry_ovf", {z32, carry32, overflow32}, m_exp);
          rcv++;
        end
      end
      if (in_valid32 && in_ready32) begin
        m_ye  = op32[0] ? ~y32 : y32;
        m_cin = (op32 == OP_ADD) ? 1'b0 : (op32 == OP_SUB) ? 1'b1 : cf_m;
        m_sum = {1'b0, x32} + {1'b0, m_ye} + {32'd0, m_cin};
        m_ovf = (x32[31] == m_ye[31]) && (m_sum[31] != x32[31]);
        cf_m  = m_sum[32];
        exp_q.push_back({m_sum[31:0], m_sum[32], m_ovf});
        sent++;
      end
    end
  end

  int          k;
  logic [15:0] got[$];

  initial begin
    rst_n = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; op16 = OP_ADD; x16 = '0; y16 = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; op32 = OP_ADD; x32 = '0; y32 = '0;
    #12;
    chk("rst_out_valid", out_valid16, 0);
    chk("rst_z", z16, 0);
    chk("rst_flags", flags16, 0);
    chk("rst_in_ready", in_ready16, 1);
    rst_n = 1'b1;
    step();

    // ADD 7FFF + 1 -> 8000: sign, overflow, odd parity
    one_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001);
    chk("add_ovf_z", z16, 16'h8000);
    chk("add_ovf_flags", flags16, 5'b10001);
    step();
    chk("add_ovf_drained", out_valid16, 0);

    // SUB 5 - 5 -> 0, no borrow
    one_op("sub_zero", OP_SUB, 16'h0005, 16'h0005);
    chk("sub_zero_z", z16, 16'h0000);
    chk("sub_zero_flags", flags16, 5'b01110);
    step();

    // SUB 8000 - 1 -> 7FFF: signed overflow
    one_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001);
    chk("sub_ovf_z", z16, 16'h7FFF);
    chk("sub_ovf_flags", flags16, 5'b00101);
    step();

    // Back-to-back ADD FFFF+1 then ADC 0+0 with no bubble
    out_ready16 = 1'b1;
    drive16(OP_ADD, 16'hFFFF, 16'h0001);
    step();
    drive16(OP_ADC, 16'h0000, 16'h0000);
    step();
    in_valid16 = 1'b0;
    chk("b2b_add_valid", out_valid16, 1);
    chk("b2b_add_z", z16, 16'h0000);
    chk("b2b_add_flags", flags16, 5'b01110);
    step();
    chk("b2b_adc_valid", out_valid16, 1);
    chk("b2b_adc_z", z16, 16'h0001);
    chk("b2b_adc_flags", flags16, 5'b00000);
    step();

    // SBC 0 - 0 with cf=0 -> FFFF, borrow
    one_op("sbc", OP_SBC, 16'h0000, 16'h0000);
    chk("sbc_z", z16, 16'hFFFF);
    chk("sbc_flags", flags16, 5'b10010);
    step();

    // Backpressure: out_ready low, only two beats fit
    out_ready16 = 1'b0;
    k = 1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive16(OP_ADD, 16'(k), 16'h0000);
      #1;
      if (in_ready16) k++;
      step();
    end
    chk("bp_accepts", k - 1, 2);
    chk("bp_in_ready_low", in_ready16, 0);
    chk("bp_hold_valid", out_valid16, 1);
    chk("bp_hold_z", z16, 16'h0001);
    got.delete();
    for (int cyc = 0; cyc < 20 && got.size() < 4; cyc++) begin
      out_ready16 = 1'b1;
      in_valid16  = (k <= 4);
      x16         = 16'(k);
      #1;
      if (out_valid16) got.push_back(z16);
      if (in_valid16 && in_ready16) k++;
      step();
    end
    in_valid16 = 1'b0;
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk($sformatf("bp_order_%0d", i), got[i], i + 1);
    chk("bp_drained", out_valid16, 0);

    // Reset with both stages full and cf=1
    out_ready16 = 1'b0;
    drive16(OP_ADD, 16'hFFFF, 16'h0001);
    step();
    drive16(OP_ADD, 16'h0001, 16'h0002);
    step();
    in_valid16 = 1'b0;
    chk("midrst_pre_valid", out_valid16, 1);
    chk("midrst_pre_cf", dut16.cf, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid16, 0);
    chk("midrst_cf", dut16.cf, 0);
    chk("midrst_z", z16, 0);
    chk("midrst_flags", flags16, 0);
    #2;
    rst_n = 1'b1;
    step();
    one_op("post_rst_adc", OP_ADC, 16'h0001, 16'h0001);
    chk("post_rst_adc_z", z16, 16'h0002);
    chk("post_rst_adc_flags", flags16, 5'b00000);
    step();

    // Random sweep on the 32-bit instance with random output stalls
    sweep_on = 1'b1;
    for (int cyc = 0; cyc < 60000 && rcv < NSWEEP; cyc++) begin
      in_valid32  = (sent < NSWEEP) && ($urandom_range(0, 3) != 0);
      op32        = 2'($urandom_range(0, 3));
      x32         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      y32         = ($urandom_range(0, 7) == 0) ? 32'h0000_0000 : $urandom;
      out_ready32 = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid32 = 1'b0;
    chk("sweep_received", rcv, NSWEEP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
